// File: rtl/crossover_engine.sv
`default_nettype none
// ============================================================================
// Module   : crossover_engine
// Purpose  : Builds one child gene from two parents with single-point,
//            two-point or uniform crossover, gated by an LFSR probability draw.
// Revision : 1.0
// ============================================================================
module crossover_engine #(
  parameter int          GENE_W  = 32,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [GENE_W-1:0]  parent_a,
  input  logic [GENE_W-1:0]  parent_b,
  input  logic               parent_valid,
  output logic               parent_ready,
  input  logic [1:0]         crossover_mode,
  input  logic [7:0]         crossover_prob,
  output logic [GENE_W-1:0]  crossover_gene,
  output logic               gene_valid,
  input  logic               gene_ready,
  output logic               crossover_flag,
  output logic [COUNT_W-1:0] child_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t               r_state;
  logic [15:0]          r_lfsr;
  logic [15:0]          r_ra;
  logic [GENE_W-1:0]    r_par_a;
  logic [GENE_W-1:0]    r_par_b;
  logic [1:0]           r_mode;
  logic [7:0]           r_prob;
  logic [GENE_W-1:0]    r_gene;
  logic                 r_flag;
  logic                 r_gene_valid;
  logic                 r_parent_ready;
  logic [COUNT_W-1:0]   r_count;

  logic                 w_fb;
  logic                 w_do_x;
  logic [4:0]           w_p1;
  logic [4:0]           w_p2;
  logic [4:0]           w_lo;
  logic [4:0]           w_hi;
  logic [31:0]          w_uni;
  logic [GENE_W-1:0]    w_mask;
  logic [GENE_W-1:0]    w_child;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // R_b is the live LFSR value during DRAW; R_a was captured at acceptance.
  assign w_do_x = (r_ra[7:0] < r_prob) && (r_mode != 2'd3);
  assign w_p1   = r_lfsr[4:0];
  assign w_p2   = r_lfsr[12:8];
  assign w_lo   = (w_p1 < w_p2) ? w_p1 : w_p2;
  assign w_hi   = (w_p1 < w_p2) ? w_p2 : w_p1;
  assign w_uni  = {r_ra, r_lfsr};

  // Mask bit 1 selects the bit from parent B.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < GENE_W; i++) begin
      case (r_mode)
        2'd0:    w_mask[i] = (5'(i) >= w_p1);
        2'd1:    w_mask[i] = (5'(i) >= w_lo) && (5'(i) < w_hi);
        2'd2:    w_mask[i] = w_uni[i];
        default: w_mask[i] = 1'b0;
      endcase
    end
    if (!w_do_x) begin
      w_mask = '0;
    end
  end

  assign w_child = (r_par_a & ~w_mask) | (r_par_b & w_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_lfsr         <= SEED;
      r_ra           <= '0;
      r_par_a        <= '0;
      r_par_b        <= '0;
      r_mode         <= '0;
      r_prob         <= '0;
      r_gene         <= '0;
      r_flag         <= 1'b0;
      r_gene_valid   <= 1'b0;
      r_parent_ready <= 1'b0;
      r_count        <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        ST_IDLE: begin
          if (parent_valid && r_parent_ready) begin
            r_par_a        <= parent_a;
            r_par_b        <= parent_b;
            r_mode         <= crossover_mode;
            r_prob         <= crossover_prob;
            r_ra           <= r_lfsr;
            r_parent_ready <= 1'b0;
            r_state        <= ST_DRAW;
          end else begin
            r_parent_ready <= 1'b1;
          end
        end
        ST_DRAW: begin
          r_gene       <= w_child;
          r_flag       <= w_do_x;
          r_gene_valid <= 1'b1;
          r_state      <= ST_OUT;
        end
        ST_OUT: begin
          // Ready goes high together with the handshake so a new pair can be
          // taken on the very next edge, giving a 3-cycle child period.
          if (gene_ready) begin
            r_gene_valid   <= 1'b0;
            r_count        <= r_count + 1'b1;
            r_parent_ready <= 1'b1;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign parent_ready   = r_parent_ready;
  assign crossover_gene = r_gene;
  assign crossover_flag = r_flag;
  assign gene_valid     = r_gene_valid;
  assign child_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_crossover_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossover_engine
// Purpose  : Scoreboard bench for crossover_engine using an LFSR reference model.
// Revision : 1.0
// ============================================================================
module tb_crossover_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] parent_a = '0;
  logic [31:0] parent_b = '0;
  logic        parent_valid = 1'b0;
  logic        parent_ready;
  logic [1:0]  crossover_mode = '0;
  logic [7:0]  crossover_prob = '0;
  logic [31:0] crossover_gene;
  logic        gene_valid;
  logic        gene_ready = 1'b1;
  logic        crossover_flag;
  logic [15:0] child_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = '0;
  logic [15:0] m_lfsr;
  logic [32:0] exp_q[$];

  crossover_engine #(.GENE_W(32), .SEED(16'hACE1), .COUNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .parent_a       (parent_a),
    .parent_b       (parent_b),
    .parent_valid   (parent_valid),
    .parent_ready   (parent_ready),
    .crossover_mode (crossover_mode),
    .crossover_prob (crossover_prob),
    .crossover_gene (crossover_gene),
    .gene_valid     (gene_valid),
    .gene_ready     (gene_ready),
    .crossover_flag (crossover_flag),
    .child_count    (child_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // Returns {flag, child}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] mode, input logic [7:0] prob,
                                        input logic [15:0] ra);
    logic [15:0] rb;
    logic [31:0] child;
    logic [31:0] m;
    logic        dox;
    int          p, p2, lo, hi;
    rb    = lfsr_step(ra);
    dox   = (ra[7:0] < prob) && (mode != 2'd3);
    child = a;
    p     = int'(rb[4:0]);
    p2    = int'(rb[12:8]);
    lo    = (p < p2) ? p : p2;
    hi    = (p < p2) ? p2 : p;
    m     = {ra, rb};
    if (dox) begin
      for (int i = 0; i < 32; i++) begin
        if (mode == 2'd0)      child[i] = (i < p) ? a[i] : b[i];
        else if (mode == 2'd1) child[i] = (i >= lo && i < hi) ? b[i] : a[i];
        else                   child[i] = m[i] ? b[i] : a[i];
      end
    end
    return {dox, child};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_parent(input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] mode, input logic [7:0] prob);
    int n;
    n = 0;
    while (!parent_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!parent_ready) begin
      total++; bad++;
      $display("FAIL send_timeout parent_ready=%0b required=1", parent_ready);
      return;
    end
    parent_a       = a;
    parent_b       = b;
    crossover_mode = mode;
    crossover_prob = prob;
    parent_valid   = 1'b1;
    exp_q.push_back(model(a, b, mode, prob, m_lfsr));
    @(negedge clk);
    parent_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!gene_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!gene_valid) begin
      total++; bad++;
      $display("FAIL %s valid_timeout gene_valid=%0b required=1", name, gene_valid);
    end
  endtask

  task automatic collect_child(input string name);
    logic [32:0] e;
    gene_ready = 1'b1;
    wait_valid(name);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s empty_queue got=%h required=none", name, crossover_gene);
      @(negedge clk);
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (crossover_gene !== e[31:0]) begin
      bad++;
      $display("FAIL %s gene got=%h required=%h", name, crossover_gene, e[31:0]);
    end
    total++;
    if (crossover_flag !== e[32]) begin
      bad++;
      $display("FAIL %s flag got=%0b required=%0b", name, crossover_flag, e[32]);
    end
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    total++;
    if (child_count !== exp_count) begin
      bad++;
      $display("FAIL %s count got=%0d required=%0d", name, child_count, exp_count);
    end
    total++;
    if (gene_valid !== 1'b0 || parent_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s post_hs valid=%0b ready=%0b required valid=0 ready=1",
               name, gene_valid, parent_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (parent_ready !== 1'b0 || gene_valid !== 1'b0 || crossover_flag !== 1'b0 ||
        crossover_gene !== 32'h0 || child_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_state ready=%0b valid=%0b flag=%0b gene=%h count=%0d required all 0",
               parent_ready, gene_valid, crossover_flag, crossover_gene, child_count);
    end
    rst = 1'b0;
    exp_count = '0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (parent_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%0b required=1", parent_ready);
    end
  endtask

  task automatic test_first();
    send_parent(32'hFFFF_FFFF, 32'h0, 2'd0, 8'd0);
    total++;
    if (gene_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_latency_t1 gene_valid=%0b required=0", gene_valid);
    end
    @(negedge clk);
    total++;
    if (gene_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_latency_t2 gene_valid=%0b required=1", gene_valid);
    end
    total++;
    if (crossover_gene !== 32'hFFFF_FFFF || crossover_flag !== 1'b0) begin
      bad++;
      $display("FAIL first_child gene=%h flag=%0b required=ffffffff/0", crossover_gene, crossover_flag);
    end
    collect_child("first");
  endtask

  task automatic test_mode(input logic [1:0] mode, input logic [7:0] prob, input string name);
    for (int k = 0; k < 50; k++) begin
      send_parent(32'hFFFF_FFFF, 32'h0, mode, prob);
      collect_child(name);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      send_parent($urandom, $urandom, 2'($urandom_range(0, 3)), 8'($urandom));
      collect_child("b2b");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] g;
    logic        f;
    gene_ready = 1'b0;
    send_parent(32'hFFFF_FFFF, 32'h0, 2'd2, 8'd255);
    wait_valid("bp");
    g = crossover_gene;
    f = crossover_flag;
    for (int k = 0; k < 10; k++) begin
      parent_valid = k[0];
      parent_a     = $urandom;
      parent_b     = $urandom;
      @(negedge clk);
      total++;
      if (crossover_gene !== g || crossover_flag !== f || parent_ready !== 1'b0 ||
          gene_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold gene=%h flag=%0b ready=%0b valid=%0b required %h/%0b/0/1",
                 crossover_gene, crossover_flag, parent_ready, gene_valid, g, f);
      end
    end
    parent_valid = 1'b0;
    collect_child("bp");
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_count = '0;
    for (int k = 0; k < 5; k++) begin
      send_parent(32'hFFFF_FFFF, 32'h0, 2'd0, 8'd255);
      collect_child("mid_pre");
    end
    gene_ready = 1'b0;
    send_parent(32'hFFFF_FFFF, 32'h0, 2'd1, 8'd255);
    wait_valid("mid");
    total++;
    if (child_count !== 16'd5) begin
      bad++;
      $display("FAIL mid_count_before got=%0d required=5", child_count);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (gene_valid !== 1'b0 || child_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_async_reset valid=%0b count=%0d required 0/0", gene_valid, child_count);
    end
    exp_q.delete();
    exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_parent(32'hFFFF_FFFF, 32'h0, 2'd2, 8'd255);
    collect_child("mid_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_first();
    test_mode(2'd0, 8'd255, "single");
    test_mode(2'd1, 8'd255, "two_point");
    test_mode(2'd2, 8'd255, "uniform");
    for (int k = 0; k < 10; k++) begin
      send_parent(32'hFFFF_FFFF, 32'h0, 2'd3, 8'd255);
      collect_child("none");
      send_parent(32'h1234_5678, 32'h9ABC_DEF0, 2'd2, 8'd0);
      collect_child("prob0");
    end
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crossover_engine.md
Name: crossover_engine

Overview:
- Produces one crossover child gene from two parent genes and feeds it as crossover_gene to the perturbation stage directly downstream.
- Supports single-point, two-point and uniform crossover, gated by a probability threshold.
- Randomness comes from an internal 16-bit LFSR. Parents arrive and the child leaves over valid/ready handshakes.

Parameters:
- GENE_W, 32, gene width in bits; fixed at 32 for this revision (point fields are 5 bits).
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- COUNT_W, 16, width of child_count.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- parent_a  input  32  first parent gene
- parent_b  input  32  second parent gene
- parent_valid  input  1  parent pair valid
- parent_ready  output  1  engine can accept a parent pair
- crossover_mode  input  2  0 single-point, 1 two-point, 2 uniform, 3 none
- crossover_prob  input  8  crossover threshold
- crossover_gene  output  32  child gene
- gene_valid  output  1  child gene valid
- gene_ready  input  1  downstream accepts child
- crossover_flag  output  1  1 = crossover was applied to current child
- child_count  output  COUNT_W  children delivered, wraps

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-high.
  - State goes to IDLE and LFSR loads SEED.
  - parent_ready, gene_valid, crossover_flag, crossover_gene and child_count all go to 0.
  - parent_ready is registered and rises on the first posedge after rst deasserts.
- LFSR:
  - Free-runs every cycle when not in reset.
  - Next value is {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- FSM states: IDLE, DRAW, OUT.
- IDLE:
  - parent_ready=1.
  - On parent_valid&parent_ready (cycle T): register parent_a, parent_b, crossover_mode and crossover_prob.
  - Also register R_a = current lfsr.
  - Set parent_ready=0 and go to DRAW.
- DRAW (T+1):
  - Register R_b = current lfsr.
  - Compute the child and register it into crossover_gene and crossover_flag.
  - Set gene_valid=1 and go to OUT. gene_valid is first seen high at T+2.
- Child computation, bit i, with mask bit 1 meaning the bit is taken from B:
  - do_x = (R_a[7:0] < prob) && (mode != 3).
  - If !do_x: child = parent_a and crossover_flag=0.
  - Mode 0: p = R_b[4:0]; bit i from A if i<p, else from B. p=0 gives child = parent_b.
  - Mode 1: p1 = R_b[4:0], p2 = R_b[12:8], lo = min, hi = max. Bit i from B if lo<=i<hi, else from A. lo==hi gives child = parent_a with crossover_flag still 1.
  - Mode 2: mask = {R_a, R_b}; bit i from B if mask[i], else from A.
- Probability boundaries:
  - prob=0: crossover never applied.
  - prob=255: crossover applied unless R_a[7:0]==8'hFF.
- OUT:
  - crossover_gene and crossover_flag are held stable while gene_valid=1 and gene_ready=0.
  - On gene_valid&gene_ready: gene_valid=0, child_count+1 (wrapping at 2^COUNT_W), go to IDLE. parent_ready=1 the next cycle.
- Throughput: one child per 3 cycles minimum.
  - parent_valid during DRAW/OUT is ignored; the upstream must hold its data.
  - Input changes after acceptance do not affect the child in flight.
- Reset mid-operation: the in-flight child is discarded and gene_valid drops immediately (asynchronously). child_count clears and the LFSR sequence restarts from SEED.
- gene_ready asserted while gene_valid=0 has no effect.

Test Plan:
- Reset release; A=32'hFFFF_FFFF, B=0, prob=0, mode=0, gene_ready=1 → parent_ready high 1 cycle after release; child 32'hFFFF_FFFF at T+2, crossover_flag=0, child_count=1.
- A=32'hFFFF_FFFF, B=0, prob=255, mode=0, 50 children → each child equals (1<<p)-1 with p=R_b[4:0]; child and crossover_flag match a bit-exact LFSR reference model.
- Same parents, mode=1 and mode=2, 50 children each → two-point child has zeros only in [lo,hi); uniform child equals ~{R_a,R_b}; all bit-exact vs model.
- mode=3, prob=255 → child=parent_a and crossover_flag=0 on every transaction.
- Backpressure: gene_ready=0 for 10 cycles after gene_valid → crossover_gene and crossover_flag stable, parent_ready=0, parent_valid pulses ignored; gene_ready=1 → one handshake, count+1.
- Assert rst in OUT with child_count=5 → gene_valid=0 and child_count=0 without a clock edge; first child after release matches the model from SEED.
